mult_seq_ctrl: RTL and testbench

//  Sequential shift-add multiplier controller: accepts an unsigned A x B operand pair over
//  a valid/ready handshake and sequences one A_W-bit ripple-carry add per multiplier bit.

---
 rtl/mult_seq_ctrl_if.sv | 43 ++++
 rtl/mult_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Bundle of the handshake signals for the sequential multiplier controller.
//
// Handshake rules (apply to both the operand and the product channel):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   Once valid is raised the sender holds valid and its data stable until the
//   transfer; ready may change freely and never depends combinationally on valid.
//
// Signals
//   clr        producer -> ctrl   synchronous abort back to IDLE
//   in_valid   producer -> ctrl   operand pair valid
//   in_ready   ctrl -> producer   controller can accept operands
//   a_in       producer -> ctrl   multiplicand, unsigned, A_W bits
//   b_in       producer -> ctrl   multiplier, unsigned, B_W bits
//   out_valid  ctrl -> consumer   product valid
//   out_ready  consumer -> ctrl   consumer accepts product
//   p_out      ctrl -> consumer   product a*b, A_W+B_W bits
//   busy       ctrl -> observer   high while an operation is in RUN or DONE
//
// Modports: master = producer/consumer side, slave = the controller.
interface mult_seq_ctrl_if #(
  parameter int A_W = 4,
  parameter int B_W = 3
);
  logic               clr;
  logic               in_valid;
  logic               in_ready;
  logic [A_W-1:0]     a_in;
  logic [B_W-1:0]     b_in;
  logic               out_valid;
  logic               out_ready;
  logic [A_W+B_W-1:0] p_out;
  logic               busy;

  modport master (
    output clr, in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, p_out, busy
  );

  modport slave (
    input  clr, in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, p_out, busy
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier controller.
//
// Accepts an unsigned a_in x b_in pair over a valid/ready handshake, then
// performs one A_W-bit add and one right shift per multiplier bit (B_W steps),
// reusing a single adder. The product is held on p_out with out_valid until
// the consumer takes it; only then does the controller return to IDLE.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        mult_seq_ctrl_if.slave (clr, operand and product handshakes, busy)
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
module mult_seq_ctrl #(
  parameter int A_W = 4,
  parameter int B_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_seq_ctrl_if.slave bus,
  output logic [1:0]  dbg_state
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [A_W-1:0]   mcand;
  logic [P_W-1:0]   p;
  logic [CNT_W-1:0] cnt;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [P_W-1:0]   p_out_r;

  // One shift-add step. P holds the partial product in its upper A_W bits and
  // the not-yet-consumed multiplier bits in its lower B_W bits. The sum is
  // A_W+1 bits wide so the carry lands in the new MSB after the shift.
  // The shift is written as a right shift of the concatenation so that B_W=1
  // needs no empty slice.
  logic [A_W-1:0] p_hi;
  logic [A_W:0]   sum;
  logic [P_W-1:0] p_next;

  always_comb begin
    p_hi   = p[P_W-1:B_W];
    sum    = p[0] ? ({1'b0, p_hi} + {1'b0, mcand}) : {1'b0, p_hi};
    p_next = P_W'({sum, p[B_W-1:0]} >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mcand       <= '0;
      p           <= '0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      p_out_r     <= '0;
    end else if (bus.clr) begin
      // Abort from any state; the last delivered product stays on p_out.
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            mcand      <= bus.a_in;
            p          <= {{A_W{1'b0}}, bus.b_in};
            cnt        <= '0;
            state      <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            p_out_r     <= p_next;
          end
        end
        DONE: begin
          // in_ready only rises after the return to IDLE, so a new operand is
          // never taken in the same cycle the product leaves.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.p_out     = p_out_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl (A_W=4, B_W=3).
// Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
module tb_mult_seq_ctrl;

  localparam int A_W = 4;
  localparam int B_W = 3;
  localparam int P_W = A_W + B_W;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mult_seq_ctrl_if #(.A_W(A_W), .B_W(B_W)) bus ();

  mult_seq_ctrl #(.A_W(A_W), .B_W(B_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int             total = 0;
  int             bad   = 0;
  logic [P_W-1:0] exp_q[$];
  bit             sb_on = 1'b0;
  int             rcv_cnt = 0;
  logic [P_W-1:0] last_p = '0;

  typedef struct {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [P_W-1:0] exp_p;
    string          name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (sb_on && rst_n && !bus.clr) begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(P_W'(32'(bus.a_in) * 32'(bus.b_in)));
      if (bus.out_valid && bus.out_ready) begin
        rcv_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got product %0d with no operation outstanding", bus.p_out);
        end else begin
          check("sb_product", 32'(bus.p_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Returns at the falling edge where
  // out_valid is first seen; lat counts rising edges waited.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) return;
      @(posedge clk);
      lat++;
    end
  endtask

  // Full operation with out_ready held high; enters and leaves 1ns after a rising edge.
  task automatic do_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                       input logic [P_W-1:0] exp_p, input string tag);
    int lat;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready_before"}, 32'(bus.in_ready), 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_out(lat);
    check({tag, "_latency"}, lat, 3);
    check({tag, "_p_out"}, 32'(bus.p_out), 32'(exp_p));
    check({tag, "_busy_done"}, 32'(bus.busy), 1);
    check({tag, "_in_ready_done"}, 32'(bus.in_ready), 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_in_ready_after"}, 32'(bus.in_ready), 1);
    check({tag, "_out_valid_after"}, 32'(bus.out_valid), 0);
    check({tag, "_busy_after"}, 32'(bus.busy), 0);
    last_p = exp_p;
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int ov_seen;

    vecs[0] = '{4'd13, 3'd5, 7'd65,  "basic_13x5"};
    vecs[1] = '{4'd15, 3'd7, 7'd105, "max_15x7"};
    vecs[2] = '{4'd0,  3'd7, 7'd0,   "zero_a"};
    vecs[3] = '{4'd15, 3'd0, 7'd0,   "zero_b"};
    vecs[4] = '{4'd1,  3'd1, 7'd1,   "one_1x1"};
    vecs[5] = '{4'd8,  3'd4, 7'd32,  "msb_8x4"};
    vecs[6] = '{4'd7,  3'd3, 7'd21,  "mid_7x3"};
    vecs[7] = '{4'd10, 3'd6, 7'd60,  "mid_10x6"};

    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_p_out", 32'(bus.p_out), 0);
    check("rst_state", 32'(dbg_state), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp_p, vecs[i].name);

    // Backpressure: product held while out_ready is low, queued operand waits
    bus.a_in = 4'd11; bus.b_in = 3'd6; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_out(lat);
    check("bp_latency", lat, 3);
    @(posedge clk);
    #1 bus.a_in = 4'd3; bus.b_in = 3'd2; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid_held", 32'(bus.out_valid), 1);
      check("bp_p_out_held", 32'(bus.p_out), 66);
      check("bp_in_ready_low", 32'(bus.in_ready), 0);
      check("bp_state_done", 32'(dbg_state), 2);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_no_accept_in_done", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(bus.in_ready), 1);
    check("bp_release_out_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_out(lat);
    check("bp_queued_latency", lat, 3);
    check("bp_queued_p_out", 32'(bus.p_out), 6);
    @(posedge clk);
    #1;
    last_p = 7'd6;

    // Abort in the second RUN cycle
    bus.a_in = 4'd12; bus.b_in = 3'd7; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.clr = 1'b0;
    @(negedge clk);
    check("clr_state_idle", 32'(dbg_state), 0);
    check("clr_busy", 32'(bus.busy), 0);
    check("clr_in_ready", 32'(bus.in_ready), 1);
    check("clr_p_out_kept", 32'(bus.p_out), 32'(last_p));
    ov_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    check("clr_no_out_valid", ov_seen, 0);
    @(posedge clk);
    #1;
    do_op(4'd9, 3'd6, 7'd54, "after_clr");

    // clr wins over in_valid in IDLE
    bus.a_in = 4'd5; bus.b_in = 3'd5; bus.in_valid = 1'b1; bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.clr = 1'b0;
    @(negedge clk);
    check("clr_blocks_accept_busy", 32'(bus.busy), 0);
    check("clr_blocks_accept_state", 32'(dbg_state), 0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of RUN
    bus.a_in = 4'd7; bus.b_in = 3'd7; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 1);
    check("arst_out_valid", 32'(bus.out_valid), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_p_out", 32'(bus.p_out), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    check("arst_no_output", ov_seen, 0);
    @(posedge clk);
    #1;

    // Exhaustive: all 128 pairs with random gaps and random backpressure
    sb_on = 1'b1;
    fork
      begin : producer
        for (int idx = 0; idx < 128; idx++) begin
          int  gap;
          bit  acc;
          logic [6:0] code;
          code = 7'(idx);
          gap = $urandom_range(0, 2);
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
          bus.a_in     = code[6:3];
          bus.b_in     = code[2:0];
          bus.in_valid = 1'b1;
          acc = 1'b0;
          for (int w = 0; w < 100 && !acc; w++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
          end
          bus.in_valid = 1'b0;
          if (!acc) begin
            total++;
            bad++;
            $display("FAIL exh_accept_timeout: operand %0d not accepted, required acceptance", idx);
            break;
          end
        end
      end
      begin : consumer
        for (int c = 0; c < 6000 && rcv_cnt < 128; c++) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    sb_on = 1'b0;
    bus.out_ready = 1'b1;
    check("exh_received_count", rcv_cnt, 128);
    check("exh_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
